if_stage: RTL

- Instruction-fetch stage; sits directly upstream of the decode stage.
- Owns the PC and issues word fetches on a request/grant/response instruction-memory port.
- Buffers returned instructions with their PCs in a small queue and presents them as pc_out/instr_out/valid_out, matching decode's pc_in/instr_in/valid_in.
- Handles redirects from branch/jump resolution: squashes buffered and in-flight fetches, then restarts at the new PC.

---
 rtl/if_stage.sv | 118 +++++++++++
 1 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, issues word fetches on a req/gnt/rvalid port,
// and buffers returned words with their PCs in a small queue presented to decode.
module if_stage #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              FQ_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            flush,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] instr_out,
  output logic            valid_out
);

  localparam int PTR_W = $clog2(FQ_DEPTH);
  localparam int CNT_W = $clog2(FQ_DEPTH + 1);

  logic [XLEN-1:0]  fetch_pc_q, resp_pc_q;
  logic [CNT_W-1:0] outstanding_q, outstanding_d;
  logic [CNT_W-1:0] discard_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] rptr_q, wptr_q;
  logic [XLEN-1:0]  fq_pc_q    [FQ_DEPTH];
  logic [XLEN-1:0]  fq_instr_q [FQ_DEPTH];

  logic           empty, full, gnt_acc, drop, push, pop;
  logic [CNT_W:0] inflight;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CNT_W'(FQ_DEPTH));
  // Queue slots plus owed responses never exceed the depth, so every response has room.
  assign inflight = {1'b0, count_q} + {1'b0, outstanding_q};
  assign imem_req = ~rst & ~flush & (inflight < (CNT_W+1)'(FQ_DEPTH));
  assign imem_addr = fetch_pc_q;
  assign gnt_acc  = imem_req & imem_gnt;

  assign drop      = imem_rvalid & (discard_q != '0);
  assign push      = imem_rvalid & ~drop & ~flush;
  assign valid_out = ~empty & ~flush;
  assign pop       = valid_out & ~stall;

  assign pc_out    = empty ? '0 : fq_pc_q[rptr_q];
  assign instr_out = empty ? '0 : fq_instr_q[rptr_q];

  always_comb begin
    outstanding_d = outstanding_q;
    case ({gnt_acc, imem_rvalid})
      2'b10:   outstanding_d = outstanding_q + CNT_W'(1);
      2'b01:   outstanding_d = outstanding_q - CNT_W'(1);
      default: outstanding_d = outstanding_q;
    endcase
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
      count_q       <= '0;
      rptr_q        <= '0;
      wptr_q        <= '0;
    end else begin
      outstanding_q <= outstanding_d;
      if (flush) begin
        // Everything still owed after this cycle belongs to the old stream.
        fetch_pc_q <= {redirect_pc[XLEN-1:2], 2'b00};
        resp_pc_q  <= {redirect_pc[XLEN-1:2], 2'b00};
        discard_q  <= outstanding_d;
        count_q    <= '0;
        rptr_q     <= '0;
        wptr_q     <= '0;
      end else begin
        if (gnt_acc) fetch_pc_q <= fetch_pc_q + XLEN'(4);
        if (drop)    discard_q  <= discard_q - CNT_W'(1);
        if (push) begin
          wptr_q    <= wptr_q + PTR_W'(1);
          resp_pc_q <= resp_pc_q + XLEN'(4);
        end
        if (pop) rptr_q <= rptr_q + PTR_W'(1);
        count_q <= count_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fq_pc_q[wptr_q]    <= resp_pc_q;
      fq_instr_q[wptr_q] <= imem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(imem_rvalid && outstanding_q == '0)) else $error("rvalid with nothing outstanding");
      assert (!(push && full && !pop)) else $error("push into full fetch queue");
      assert (imem_addr[1:0] == 2'b00) else $error("misaligned fetch address");
    end
  end

endmodule
